usb_tx_scheduler: RTL

//  Arbitrates the shared USB transmit path between two requesters: the handshake

---
 rtl/usb_tx_scheduler_if.sv | 32 +++
 rtl/usb_tx_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/usb_tx_scheduler_if.sv
// Request, grant and transmit-controller signals shared between the USB tx
// scheduler and its requesters / downstream transmit controller.
interface usb_tx_scheduler_if;
    logic       hs_req;
    logic [1:0] hs_code;
    logic       hs_grant;
    logic       data_req;
    logic [6:0] data_len;
    logic       data_grant;
    logic       data_err;
    logic       data_acked;
    logic       toggle_clr;
    logic [7:0] tx_pid;
    logic [6:0] tx_len;
    logic       tx_has_crc;
    logic       transmit_start;
    logic       tx_eop;
    logic       busy;
    logic       timeout_err;

    modport master (
        output hs_req, hs_code, data_req, data_len, data_acked, toggle_clr, tx_eop,
        input  hs_grant, data_grant, data_err, tx_pid, tx_len, tx_has_crc,
               transmit_start, busy, timeout_err
    );

    modport slave (
        input  hs_req, hs_code, data_req, data_len, data_acked, toggle_clr, tx_eop,
        output hs_grant, data_grant, data_err, tx_pid, tx_len, tx_has_crc,
               transmit_start, busy, timeout_err
    );
endinterface

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake vs bulk-IN data packets onto one USB transmit controller,
// tracks the DATA0/DATA1 toggle, waits for EOP (with timeout) and enforces the gap.
module usb_tx_scheduler #(
    parameter int IPG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_LEN        = 64
) (
    input  logic               clk,
    input  logic               rst,
    usb_tx_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_EOP = 2'd2,
        GAP      = 2'd3
    } state_t;

    localparam int CNT_MAX = (TIMEOUT_CYCLES > IPG_CYCLES) ? TIMEOUT_CYCLES : IPG_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // The edge that would advance the count to TIMEOUT_CYCLES-1 raises the error,
    // so the pulse lands exactly TIMEOUT_CYCLES cycles after the launch cycle.
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [CW-1:0] GAP_LAST  = CW'(IPG_CYCLES - 1);
    localparam logic [6:0]    MAX_LEN_W = 7'(MAX_LEN);

    state_t        state_r;
    logic [CW-1:0] count_r;
    logic          toggle_r;
    logic          decide_s;
    logic          oversize_s;
    logic          launch_hs_s;
    logic          launch_data_s;

    function automatic logic [7:0] hs_pid(input logic [1:0] code);
        logic [7:0] pid;
        case (code)
            2'b00:   pid = 8'hD2;
            2'b01:   pid = 8'h5A;
            default: pid = 8'h1E;
        endcase
        return pid;
    endfunction

    function automatic logic [7:0] data_pid(input logic toggle);
        return toggle ? 8'h4B : 8'hC3;
    endfunction

    // Grant decision: made in IDLE and on the final gap cycle, so the idle time
    // between EOP and the next launch is exactly IPG_CYCLES.
    always_comb begin
        decide_s      = (state_r == IDLE) || ((state_r == GAP) && (count_r == GAP_LAST));
        oversize_s    = (bus.data_len > MAX_LEN_W);
        launch_hs_s   = decide_s && bus.hs_req;
        launch_data_s = decide_s && !bus.hs_req && bus.data_req && !oversize_s;
    end

    // Data toggle: clear has priority over flip; independent of packet state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_r <= 1'b0;
        end else if (bus.toggle_clr) begin
            toggle_r <= 1'b0;
        end else if (bus.data_acked) begin
            toggle_r <= ~toggle_r;
        end else begin
            toggle_r <= toggle_r;
        end
    end

    // Packet sequencer and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= IDLE;
            count_r            <= '0;
            bus.hs_grant       <= 1'b0;
            bus.data_grant     <= 1'b0;
            bus.data_err       <= 1'b0;
            bus.tx_pid         <= 8'h00;
            bus.tx_len         <= 7'd0;
            bus.tx_has_crc     <= 1'b0;
            bus.transmit_start <= 1'b0;
            bus.busy           <= 1'b0;
            bus.timeout_err    <= 1'b0;
        end else begin
            bus.transmit_start <= 1'b0;
            bus.hs_grant       <= 1'b0;
            bus.data_grant     <= 1'b0;
            bus.timeout_err    <= 1'b0;
            bus.data_err       <= decide_s && !bus.hs_req && bus.data_req && oversize_s;
            if (launch_hs_s || launch_data_s) begin
                state_r            <= LAUNCH;
                count_r            <= '0;
                bus.busy           <= 1'b1;
                bus.transmit_start <= 1'b1;
                bus.hs_grant       <= launch_hs_s;
                bus.data_grant     <= launch_data_s;
                bus.tx_pid         <= launch_hs_s ? hs_pid(bus.hs_code) : data_pid(toggle_r);
                bus.tx_len         <= launch_hs_s ? 7'd0 : bus.data_len;
                bus.tx_has_crc     <= launch_data_s;
            end else begin
                case (state_r)
                    IDLE: begin
                        bus.busy <= 1'b0;
                    end
                    LAUNCH: begin
                        state_r <= WAIT_EOP;
                        count_r <= '0;
                    end
                    WAIT_EOP: begin
                        if (bus.tx_eop) begin
                            state_r <= GAP;
                            count_r <= '0;
                        end else if (count_r == TO_LAST) begin
                            state_r         <= GAP;
                            count_r         <= '0;
                            bus.timeout_err <= 1'b1;
                        end else begin
                            count_r <= count_r + 1'b1;
                        end
                    end
                    GAP: begin
                        if (count_r == GAP_LAST) begin
                            state_r  <= IDLE;
                            count_r  <= '0;
                            bus.busy <= 1'b0;
                        end else begin
                            count_r <= count_r + 1'b1;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        count_r  <= '0;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
